// File: rtl/aximm_client.sv
// Single-outstanding AXI-MM manager: one write beat, its response, then a read-back of the
// same address, reporting whether the returned data matches and whether any response faulted.
module aximm_client #(
    parameter int AXI4_IDW       = 8,
    parameter int AXI4_ADDRW     = 64,
    parameter int AXI4_LENW      = 8,
    parameter int AXI4_SIZEW     = 3,
    parameter int AXI4_BURSTW    = 2,
    parameter int AXI4_USERW     = 64,
    parameter int AXI4_MAX_DATAW = 512,
    parameter int AXI4_RESPW     = 2,
    parameter int CLIENT_ID      = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [AXI4_ADDRW-1:0]     req_addr,
    input  logic [AXI4_MAX_DATAW-1:0] req_data,
    input  logic [AXI4_USERW-1:0]     req_dest,
    output logic                      busy,
    output logic                      done,
    output logic                      match,
    output logic                      error,
    output logic [2:0]                dbg_state,
    output logic                      aximm_client_awvalid,
    input  logic                      aximm_client_awready,
    output logic [AXI4_IDW-1:0]       aximm_client_awid,
    output logic [AXI4_ADDRW-1:0]     aximm_client_awaddr,
    output logic [AXI4_LENW-1:0]      aximm_client_awlen,
    output logic [AXI4_SIZEW-1:0]     aximm_client_awsize,
    output logic [AXI4_BURSTW-1:0]    aximm_client_awburst,
    output logic [AXI4_USERW-1:0]     aximm_client_awuser,
    output logic                      aximm_client_wvalid,
    input  logic                      aximm_client_wready,
    output logic [AXI4_IDW-1:0]       aximm_client_wid,
    output logic [AXI4_MAX_DATAW-1:0] aximm_client_wdata,
    output logic                      aximm_client_wlast,
    output logic [AXI4_USERW-1:0]     aximm_client_wuser,
    input  logic                      aximm_client_bvalid,
    output logic                      aximm_client_bready,
    input  logic [AXI4_IDW-1:0]       aximm_client_bid,
    input  logic [AXI4_RESPW-1:0]     aximm_client_bresp,
    input  logic [AXI4_USERW-1:0]     aximm_client_buser,
    output logic                      aximm_client_arvalid,
    input  logic                      aximm_client_arready,
    output logic [AXI4_IDW-1:0]       aximm_client_arid,
    output logic [AXI4_ADDRW-1:0]     aximm_client_araddr,
    output logic [AXI4_LENW-1:0]      aximm_client_arlen,
    output logic [AXI4_SIZEW-1:0]     aximm_client_arsize,
    output logic [AXI4_BURSTW-1:0]    aximm_client_arburst,
    output logic [AXI4_USERW-1:0]     aximm_client_aruser,
    input  logic                      aximm_client_rvalid,
    output logic                      aximm_client_rready,
    input  logic [AXI4_IDW-1:0]       aximm_client_rid,
    input  logic [AXI4_MAX_DATAW-1:0] aximm_client_rdata,
    input  logic [AXI4_RESPW-1:0]     aximm_client_rresp,
    input  logic                      aximm_client_rlast,
    input  logic [AXI4_USERW-1:0]     aximm_client_ruser
);
    // Handshakes: a transfer happens on the rising edge where valid and ready are both high;
    // valid and payload hold steady until then and valid is low the following cycle.

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AW   = 3'd1;
    localparam logic [2:0] S_W    = 3'd2;
    localparam logic [2:0] S_B    = 3'd3;
    localparam logic [2:0] S_AR   = 3'd4;
    localparam logic [2:0] S_R    = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    localparam logic [AXI4_IDW-1:0]    ID   = AXI4_IDW'(CLIENT_ID);
    localparam logic [AXI4_SIZEW-1:0]  SIZE = AXI4_SIZEW'($clog2(AXI4_MAX_DATAW / 8));
    localparam logic [AXI4_BURSTW-1:0] INCR = AXI4_BURSTW'(1);

    logic [2:0]                state;
    logic [AXI4_ADDRW-1:0]     addr_q;
    logic [AXI4_MAX_DATAW-1:0] data_q;
    logic [AXI4_USERW-1:0]     dest_q;

    // User sidebands on responses carry no information for this client.
    logic unused_user;
    assign unused_user = ^{aximm_client_buser, aximm_client_ruser};

    assign dbg_state          = state;
    assign aximm_client_awlen = '0;
    assign aximm_client_arlen = '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= S_IDLE;
            addr_q               <= '0;
            data_q               <= '0;
            dest_q               <= '0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            match                <= 1'b0;
            error                <= 1'b0;
            aximm_client_awvalid <= 1'b0;
            aximm_client_awid    <= '0;
            aximm_client_awaddr  <= '0;
            aximm_client_awsize  <= '0;
            aximm_client_awburst <= '0;
            aximm_client_awuser  <= '0;
            aximm_client_wvalid  <= 1'b0;
            aximm_client_wid     <= '0;
            aximm_client_wdata   <= '0;
            aximm_client_wlast   <= 1'b0;
            aximm_client_wuser   <= '0;
            aximm_client_bready  <= 1'b0;
            aximm_client_arvalid <= 1'b0;
            aximm_client_arid    <= '0;
            aximm_client_araddr  <= '0;
            aximm_client_arsize  <= '0;
            aximm_client_arburst <= '0;
            aximm_client_aruser  <= '0;
            aximm_client_rready  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr_q <= req_addr;
                        data_q <= req_data;
                        dest_q <= req_dest;
                        match  <= 1'b0;
                        error  <= 1'b0;
                        busy   <= 1'b1;
                        state  <= S_AW;
                    end
                end
                S_AW: begin
                    if (aximm_client_awvalid && aximm_client_awready) begin
                        aximm_client_awvalid <= 1'b0;
                        state                <= S_W;
                    end else begin
                        aximm_client_awvalid <= 1'b1;
                        aximm_client_awid    <= ID;
                        aximm_client_awaddr  <= addr_q;
                        aximm_client_awsize  <= SIZE;
                        aximm_client_awburst <= INCR;
                        aximm_client_awuser  <= dest_q;
                    end
                end
                S_W: begin
                    if (aximm_client_wvalid && aximm_client_wready) begin
                        aximm_client_wvalid <= 1'b0;
                        state               <= S_B;
                    end else begin
                        aximm_client_wvalid <= 1'b1;
                        aximm_client_wid    <= ID;
                        aximm_client_wdata  <= data_q;
                        aximm_client_wlast  <= 1'b1;
                        aximm_client_wuser  <= dest_q;
                    end
                end
                S_B: begin
                    if (aximm_client_bvalid && aximm_client_bready) begin
                        aximm_client_bready <= 1'b0;
                        if (aximm_client_bresp != '0 || aximm_client_bid != ID) begin
                            error <= 1'b1;
                        end
                        state <= S_AR;
                    end else begin
                        aximm_client_bready <= 1'b1;
                    end
                end
                S_AR: begin
                    if (aximm_client_arvalid && aximm_client_arready) begin
                        aximm_client_arvalid <= 1'b0;
                        state                <= S_R;
                    end else begin
                        aximm_client_arvalid <= 1'b1;
                        aximm_client_arid    <= ID;
                        aximm_client_araddr  <= addr_q;
                        aximm_client_arsize  <= SIZE;
                        aximm_client_arburst <= INCR;
                        aximm_client_aruser  <= dest_q;
                    end
                end
                S_R: begin
                    if (aximm_client_rvalid && aximm_client_rready) begin
                        aximm_client_rready <= 1'b0;
                        match               <= (aximm_client_rdata == data_q);
                        if (aximm_client_rresp != '0 || aximm_client_rid != ID || !aximm_client_rlast) begin
                            error <= 1'b1;
                        end
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        aximm_client_rready <= 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aximm_client.sv
// Bench for aximm_client: a memory-backed responder with per-channel delays and fault knobs,
// a per-cycle compare process against transaction-level expectations, and directed scenarios.
module tb_aximm_client;
    localparam int IDW = 8, ADDRW = 64, LENW = 8, SIZEW = 3, BURSTW = 2;
    localparam int USERW = 64, DW = 512, RESPW = 2, CID = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [ADDRW-1:0] req_addr = '0;
    logic [DW-1:0]    req_data = '0;
    logic [USERW-1:0] req_dest = '0;
    logic busy, done, match, error;
    logic [2:0] dbg_state;
    logic awvalid, awready = 1'b0;
    logic [IDW-1:0] awid;
    logic [ADDRW-1:0] awaddr;
    logic [LENW-1:0] awlen;
    logic [SIZEW-1:0] awsize;
    logic [BURSTW-1:0] awburst;
    logic [USERW-1:0] awuser;
    logic wvalid, wready = 1'b0;
    logic [IDW-1:0] wid;
    logic [DW-1:0] wdata;
    logic wlast;
    logic [USERW-1:0] wuser;
    logic bvalid = 1'b0, bready;
    logic [IDW-1:0] bid = '0;
    logic [RESPW-1:0] bresp = '0;
    logic [USERW-1:0] buser = '0;
    logic arvalid, arready = 1'b0;
    logic [IDW-1:0] arid;
    logic [ADDRW-1:0] araddr;
    logic [LENW-1:0] arlen;
    logic [SIZEW-1:0] arsize;
    logic [BURSTW-1:0] arburst;
    logic [USERW-1:0] aruser;
    logic rvalid = 1'b0, rready;
    logic [IDW-1:0] rid = '0;
    logic [DW-1:0] rdata = '0;
    logic [RESPW-1:0] rresp = '0;
    logic rlast = 1'b0;
    logic [USERW-1:0] ruser = '0;

    always #5 clk = ~clk;

    aximm_client #(.CLIENT_ID(CID)) dut (
        .clk(clk), .rst(rst), .start(start), .req_addr(req_addr), .req_data(req_data),
        .req_dest(req_dest), .busy(busy), .done(done), .match(match), .error(error),
        .dbg_state(dbg_state),
        .aximm_client_awvalid(awvalid), .aximm_client_awready(awready), .aximm_client_awid(awid),
        .aximm_client_awaddr(awaddr), .aximm_client_awlen(awlen), .aximm_client_awsize(awsize),
        .aximm_client_awburst(awburst), .aximm_client_awuser(awuser),
        .aximm_client_wvalid(wvalid), .aximm_client_wready(wready), .aximm_client_wid(wid),
        .aximm_client_wdata(wdata), .aximm_client_wlast(wlast), .aximm_client_wuser(wuser),
        .aximm_client_bvalid(bvalid), .aximm_client_bready(bready), .aximm_client_bid(bid),
        .aximm_client_bresp(bresp), .aximm_client_buser(buser),
        .aximm_client_arvalid(arvalid), .aximm_client_arready(arready), .aximm_client_arid(arid),
        .aximm_client_araddr(araddr), .aximm_client_arlen(arlen), .aximm_client_arsize(arsize),
        .aximm_client_arburst(arburst), .aximm_client_aruser(aruser),
        .aximm_client_rvalid(rvalid), .aximm_client_rready(rready), .aximm_client_rid(rid),
        .aximm_client_rdata(rdata), .aximm_client_rresp(rresp), .aximm_client_rlast(rlast),
        .aximm_client_ruser(ruser)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Responder knobs and memory
    int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    logic [RESPW-1:0] bresp_val = '0, rresp_val = '0;
    logic [IDW-1:0] bid_val = IDW'(CID), rid_val = IDW'(CID);
    logic rlast_val = 1'b1;
    bit r_zero = 0;
    logic [DW-1:0] mem [logic [ADDRW-1:0]];

    // Scoreboard: {match, error} per transaction, plus the request it was made with
    logic [1:0] exp_q[$];
    logic [ADDRW-1:0] exp_addr = '0;
    logic [DW-1:0]    exp_data = '0;
    logic [USERW-1:0] exp_dest = '0;

    initial begin : responder
        bit aw_fire, w_fire, ar_fire, b_fire, b_pend, r_fire, r_pend;
        int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        logic [ADDRW-1:0] cur_addr, rd_addr;
        logic [DW-1:0] cur_wdata;
        aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; b_pend = 0; r_fire = 0; r_pend = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        cur_addr = '0; rd_addr = '0; cur_wdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
                bid = '0; bresp = '0; rid = '0; rdata = '0; rresp = '0; rlast = 0;
                aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; b_pend = 0; r_fire = 0; r_pend = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                continue;
            end
            if (aw_fire) begin
                awready = 0; aw_fire = 0; aw_cnt = 0;
            end else if (awvalid) begin
                aw_cnt++;
                if (aw_cnt > aw_dly) awready = 1;
                if (awready) begin aw_fire = 1; cur_addr = awaddr; end
            end
            if (w_fire) begin
                wready = 0; w_fire = 0; w_cnt = 0;
                mem[cur_addr] = cur_wdata;
                b_pend = 1; b_cnt = 0;
            end else if (wvalid) begin
                w_cnt++;
                if (w_cnt > w_dly) wready = 1;
                if (wready) begin w_fire = 1; cur_wdata = wdata; end
            end
            if (b_fire) begin
                bvalid = 0; b_fire = 0;
            end else begin
                if (!bvalid && b_pend) begin
                    b_cnt++;
                    if (b_cnt > b_dly) begin bvalid = 1; bid = bid_val; bresp = bresp_val; b_pend = 0; end
                end
                if (bvalid && bready) b_fire = 1;
            end
            if (ar_fire) begin
                arready = 0; ar_fire = 0; ar_cnt = 0;
                r_pend = 1; r_cnt = 0;
            end else if (arvalid) begin
                ar_cnt++;
                if (ar_cnt > ar_dly) arready = 1;
                if (arready) begin ar_fire = 1; rd_addr = araddr; end
            end
            if (r_fire) begin
                rvalid = 0; r_fire = 0;
            end else begin
                if (!rvalid && r_pend) begin
                    r_cnt++;
                    if (r_cnt > r_dly) begin
                        rvalid = 1; rid = rid_val; rresp = rresp_val; rlast = rlast_val;
                        rdata = (r_zero || !mem.exists(rd_addr)) ? '0 : mem[rd_addr];
                        r_pend = 0;
                    end
                end
                if (rvalid && rready) r_fire = 1;
            end
        end
    end

    // Compare process: protocol stability, payload contents and results, every cycle
    int aw_hs = 0, ar_hs = 0;
    logic [USERW-1:0] last_awuser = '0, last_wuser = '0, last_aruser = '0;
    initial begin : compare
        bit aw_hold, aw_fired, w_hold, w_fired, ar_hold, ar_fired, b_hold, b_fired, r_hold, r_fired;
        bit post_done;
        logic [1:0] last_res;
        logic [ADDRW-1:0] aw_prev, ar_prev;
        logic [DW-1:0] w_prev;
        aw_hold = 0; aw_fired = 0; w_hold = 0; w_fired = 0; ar_hold = 0; ar_fired = 0;
        b_hold = 0; b_fired = 0; r_hold = 0; r_fired = 0; post_done = 0; last_res = '0;
        aw_prev = '0; ar_prev = '0; w_prev = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                aw_hold = 0; aw_fired = 0; w_hold = 0; w_fired = 0; ar_hold = 0; ar_fired = 0;
                b_hold = 0; b_fired = 0; r_hold = 0; r_fired = 0; post_done = 0;
                continue;
            end
            if (aw_hold) begin check("aw_held", awvalid, 1); check("aw_addr_stable", awaddr, aw_prev); end
            if (aw_fired) check("aw_dropped", awvalid, 0);
            if (w_hold) begin check("w_held", wvalid, 1); check("w_data_stable", wdata, w_prev); end
            if (w_fired) check("w_dropped", wvalid, 0);
            if (ar_hold) begin check("ar_held", arvalid, 1); check("ar_addr_stable", araddr, ar_prev); end
            if (ar_fired) check("ar_dropped", arvalid, 0);
            if (b_hold) check("bready_held", bready, 1);
            if (b_fired) check("bready_dropped", bready, 0);
            if (r_hold) check("rready_held", rready, 1);
            if (r_fired) check("rready_dropped", rready, 0);
            if (awvalid) begin
                check("awaddr", awaddr, exp_addr); check("awuser", awuser, exp_dest);
                check("awlen", awlen, 0); check("awsize", awsize, 6); check("awburst", awburst, 1);
                check("awid", awid, CID);
                last_awuser = awuser;
            end
            if (wvalid) begin
                check("wdata", wdata, exp_data); check("wuser", wuser, exp_dest);
                check("wlast", wlast, 1); check("wid", wid, CID);
                last_wuser = wuser;
            end
            if (arvalid) begin
                check("araddr", araddr, exp_addr); check("aruser", aruser, exp_dest);
                check("arlen", arlen, 0); check("arsize", arsize, 6); check("arburst", arburst, 1);
                check("arid", arid, CID);
                last_aruser = aruser;
            end
            if (!busy) check("idle_quiet", {awvalid, wvalid, arvalid, bready, rready}, 0);
            if (post_done) begin
                check("done_one_cycle", done, 0);
                check("result_held", {match, error}, last_res);
                post_done = 0;
            end
            if (done) begin
                check("busy_in_done", busy, 1);
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL done_unexpected: got done=1 expected no transaction");
                end else begin
                    last_res = exp_q.pop_front();
                    check("result", {match, error}, last_res);
                    post_done = 1;
                end
            end
            aw_hold = awvalid && !awready; aw_fired = awvalid && awready; aw_prev = awaddr;
            w_hold = wvalid && !wready;    w_fired = wvalid && wready;    w_prev = wdata;
            ar_hold = arvalid && !arready; ar_fired = arvalid && arready; ar_prev = araddr;
            b_hold = bready && !bvalid;    b_fired = bready && bvalid;
            r_hold = rready && !rvalid;    r_fired = rready && rvalid;
            if (aw_fired) aw_hs++;
            if (ar_fired) ar_hs++;
        end
    end

    // Driver tasks
    task automatic expect_txn(input logic [ADDRW-1:0] a, input logic [DW-1:0] d, input logic [USERW-1:0] u);
        logic [DW-1:0] returned;
        logic m, e;
        returned = r_zero ? '0 : d;
        m = (returned == d);
        e = (bresp_val != 0) || (bid_val != IDW'(CID)) || (rresp_val != 0) ||
            (rid_val != IDW'(CID)) || !rlast_val;
        exp_addr = a; exp_data = d; exp_dest = u;
        req_addr = a; req_data = d; req_dest = u;
        exp_q.push_back({m, e});
    endtask

    task automatic wait_done(input bit drop_start, output int lat);
        bit got;
        got = 0;
        lat = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (drop_start) start = 0;
            if (done) got = 1;
        end
        check("done_seen", got, 1);
        if (!got) exp_q.delete();
    endtask

    task automatic run_txn(input logic [ADDRW-1:0] a, input logic [DW-1:0] d,
                           input logic [USERW-1:0] u, output int lat);
        @(negedge clk);
        expect_txn(a, d, u);
        start = 1;
        wait_done(1, lat);
    endtask

    task automatic set_knobs(input int da, input int dw, input int dr, input int db, input int drr);
        aw_dly = da; w_dly = dw; ar_dly = dr; b_dly = db; r_dly = drr;
    endtask

    task automatic clear_faults();
        bresp_val = '0; rresp_val = '0; bid_val = IDW'(CID); rid_val = IDW'(CID);
        rlast_val = 1; r_zero = 0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int lat;
        int hs0;
        bit seen;
        logic [DW-1:0] pat;

        // Reset values
        rst = 1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
        check("rst_status", {busy, done, match, error}, 0);
        check("rst_state", dbg_state, 0);
        check("rst_payload", {awaddr, araddr, awuser, awsize, awburst, wlast}, 0);
        check("rst_wdata", wdata, 0);
        @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);

        // Basic write/read match, zero-wait responder
        pat = {16{32'hA5A5_A5A5}};
        run_txn(64'd5, pat, 64'd3, lat);
        check("basic_latency", lat, 11);
        check("basic_match", match, 1);
        check("basic_error", error, 0);
        check("basic_awuser", last_awuser, 64'd3);
        check("basic_wuser", last_wuser, 64'd3);
        check("basic_aruser", last_aruser, 64'd3);
        check("basic_mem", mem[64'd5], pat);

        // Backpressure: 4-cycle ready delays, 6-cycle response delays
        set_knobs(4, 4, 4, 6, 6);
        pat = {8{64'h0123_4567_89AB_CDEF}};
        run_txn(64'h100, pat, 64'd7, lat);
        check("bp_latency", lat, 33);
        check("bp_match", match, 1);
        check("bp_error", error, 0);
        set_knobs(0, 0, 0, 0, 0);

        // Data mismatch: responder returns zero
        r_zero = 1;
        run_txn(64'h40, 512'h1, 64'd2, lat);
        check("mm_match", match, 0);
        check("mm_error", error, 0);
        clear_faults();

        // Write error response; read still issued
        bresp_val = 2'b10;
        hs0 = ar_hs;
        run_txn(64'h80, 512'hDEAD_BEEF, 64'd1, lat);
        check("berr_error", error, 1);
        check("berr_match", match, 1);
        check("berr_read_issued", ar_hs, hs0 + 1);
        clear_faults();

        // Read ID fault
        rid_val = IDW'(CID + 1);
        run_txn(64'hC0, 512'h55AA, 64'd4, lat);
        check("rid_error", error, 1);
        check("rid_match", match, 1);
        clear_faults();

        // Clean transaction clears prior error
        run_txn(64'hC8, 512'h1234, 64'd4, lat);
        check("clean_error", error, 0);

        // start pulsed during W is ignored
        set_knobs(0, 3, 0, 0, 0);
        hs0 = aw_hs;
        @(negedge clk);
        expect_txn(64'h200, 512'h77, 64'd9);
        start = 1;
        @(negedge clk);
        start = 0;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (wvalid) seen = 1;
            else @(negedge clk);
        end
        check("wvalid_seen", seen, 1);
        start = 1;
        @(negedge clk);
        start = 0;
        wait_done(1, lat);
        repeat (15) @(negedge clk);
        check("pulse_ignored_busy", busy, 0);
        check("pulse_ignored_txns", aw_hs, hs0 + 1);
        set_knobs(0, 0, 0, 0, 0);

        // start held high through DONE begins a second transaction after IDLE
        hs0 = aw_hs;
        @(negedge clk);
        expect_txn(64'h300, 512'hF00D, 64'd6);
        exp_q.push_back({1'b1, 1'b0});
        start = 1;
        wait_done(0, lat);
        @(negedge clk);
        check("held_idle_gap", busy, 0);
        @(negedge clk);
        check("held_second_busy", busy, 1);
        start = 0;
        wait_done(1, lat);
        check("held_two_txns", aw_hs, hs0 + 2);
        check("held_match", match, 1);

        // Reset while waiting in R with rready high
        set_knobs(0, 0, 0, 0, 50);
        @(negedge clk);
        expect_txn(64'h400, 512'hBEEF, 64'd5);
        start = 1;
        @(negedge clk);
        start = 0;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (rready) seen = 1;
        end
        check("rready_seen", seen, 1);
        check("in_r_state", dbg_state, 5);
        rst = 1;
        exp_q.delete();
        @(negedge clk);
        #1;
        check("rstR_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
        check("rstR_status", {busy, done, match, error}, 0);
        check("rstR_state", dbg_state, 0);
        check("rstR_araddr", araddr, 0);
        @(negedge clk);
        rst = 0;
        set_knobs(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        run_txn(64'h408, 512'hCAFE, 64'd5, lat);
        check("post_rst_latency", lat, 11);
        check("post_rst_match", match, 1);
        check("post_rst_error", error, 0);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
